// File: rtl/led_sequencer_if.sv
// Board-side signals of the LED sequencer.
// The sequencer takes the master modport; the board model or top level takes the slave modport.
interface led_sequencer_if #(
  parameter int CHANNELS = 3
);
  logic                KEY;
  logic [CHANNELS-1:0] LED;
  logic [1:0]          MODE;
  logic                STEP_TICK;

  modport master (input KEY, output LED, output MODE, output STEP_TICK);
  modport slave  (output KEY, input LED, input MODE, input STEP_TICK);
endinterface

// File: rtl/led_sequencer.sv
// Status-LED sequencer: programmable step prescaler, four display modes, and a debounced mode key.
//
// state    | meaning
// BINARY   | pattern counts up once per step, LEDs show its bits
// ONE_HOT  | single lit LED rotates left once per step
// BREATHE  | all LEDs share one PWM level that ramps up and down
// OFF      | all LEDs dark, prescaler keeps ticking
module led_sequencer #(
  parameter int STEP_CYCLES     = 100_000_001,
  parameter int CHANNELS        = 3,
  parameter int PWM_BITS        = 8,
  parameter int DEBOUNCE_CYCLES = 240_000,
  parameter int ACTIVE_LOW      = 1
) (
  input logic             CLK,
  input logic             RST,
  led_sequencer_if.master bus
);

  localparam int PW = $clog2(STEP_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [PW-1:0]       PRESC_LAST    = PW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0]       PRESC_ONE     = PW'(1);
  localparam logic [DW-1:0]       DEB_LAST      = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0]       DEB_ONE       = DW'(1);
  localparam logic [PWM_BITS-1:0] LEVEL_TOP     = '1;
  localparam logic [PWM_BITS-1:0] LEVEL_ONE     = PWM_BITS'(1);
  localparam logic [CHANNELS-1:0] PATTERN_ONE   = CHANNELS'(1);
  localparam logic [CHANNELS-1:0] DARK          = {CHANNELS{ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {
    BINARY  = 2'd0,
    ONE_HOT = 2'd1,
    BREATHE = 2'd2,
    OFF     = 2'd3
  } mode_t;

  mode_t               mode;
  logic                key_s1;
  logic                key_s2;
  logic                key_acc;
  logic                key_evt;
  logic [DW-1:0]       deb_cnt;
  logic [PW-1:0]       presc;
  logic                step_tick;
  logic [CHANNELS-1:0] pattern;
  logic [PWM_BITS-1:0] level;
  logic                dir_up;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [CHANNELS-1:0] led_q;
  logic [CHANNELS-1:0] lit;

  always_comb begin
    lit = '0;
    case (mode)
      BINARY:  lit = pattern;
      ONE_HOT: lit = pattern;
      BREATHE: lit = {CHANNELS{pwm_cnt < level}};
      default: lit = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      key_s1    <= 1'b1;
      key_s2    <= 1'b1;
      key_acc   <= 1'b1;
      key_evt   <= 1'b0;
      deb_cnt   <= '0;
      presc     <= '0;
      step_tick <= 1'b0;
      mode      <= BINARY;
      pattern   <= '0;
      level     <= '0;
      dir_up    <= 1'b1;
      pwm_cnt   <= '0;
      led_q     <= DARK;
    end else begin
      key_s1  <= bus.KEY;
      key_s2  <= key_s1;
      key_evt <= 1'b0;
      if (key_s2 == key_acc) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        key_acc <= key_s2;
        deb_cnt <= '0;
        key_evt <= ~key_s2;   // only a press (1->0) is an event
      end else begin
        deb_cnt <= deb_cnt + DEB_ONE;
      end

      pwm_cnt <= pwm_cnt + LEVEL_ONE;
      led_q   <= lit ^ DARK;

      // A key event restarts the new mode from scratch and swallows a coincident step.
      if (key_evt) begin
        mode      <= mode_t'(mode + 2'd1);
        presc     <= '0;
        step_tick <= 1'b0;
        pattern   <= (mode == BINARY) ? PATTERN_ONE : '0;
        level     <= '0;
        dir_up    <= 1'b1;
      end else begin
        if (presc == PRESC_LAST) begin
          presc     <= '0;
          step_tick <= 1'b0;
        end else begin
          presc     <= presc + PRESC_ONE;
          step_tick <= ((presc + PRESC_ONE) == PRESC_LAST);
        end

        if (step_tick) begin
          case (mode)
            BINARY: pattern <= pattern + PATTERN_ONE;
            ONE_HOT: pattern <= {pattern[CHANNELS-2:0], pattern[CHANNELS-1]};
            BREATHE: begin
              if (dir_up) begin
                if (level == LEVEL_TOP) begin
                  dir_up <= 1'b0;
                  level  <= level - LEVEL_ONE;
                end else begin
                  level <= level + LEVEL_ONE;
                end
              end else begin
                if (level == '0) begin
                  dir_up <= 1'b1;
                  level  <= level + LEVEL_ONE;
                end else begin
                  level <= level - LEVEL_ONE;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.LED       = led_q;
  assign bus.MODE      = mode;
  assign bus.STEP_TICK = step_tick;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with STEP_CYCLES=4, DEBOUNCE_CYCLES=8, CHANNELS=3, PWM_BITS=3, active-low LEDs.
module tb_led_sequencer;

  localparam int CH = 3;

  typedef struct {
    logic       key;
    int         at;     // edges after reset release
    logic [2:0] led;
    logic       tick;
    logic [1:0] mode;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_bad = 0;

  int         cyc = 0;
  int         r_edge = 0;
  int         t0 = 0;
  int         exp_mode = 0;
  int         evt_edge = -1;
  logic [2:0] lit_prev = 3'b000;
  vec_t       vecs [16];

  led_sequencer_if #(.CHANNELS(CH)) bus ();

  led_sequencer #(
    .STEP_CYCLES(4), .CHANNELS(CH), .PWM_BITS(3), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  always #5 CLK = ~CLK;

  function automatic int tri_level(int k);
    int p = k % 14;
    return (p <= 7) ? p : 14 - p;
  endfunction

  // Lit vector implied by the state after the current edge (closed form from step count).
  function automatic logic [2:0] model_lit();
    int k   = (cyc - t0) / 4;
    int pwm = (cyc - r_edge) % 8;
    case (exp_mode)
      0:       return 3'(k % 8);
      1:       return 3'(1 << (k % 3));
      2:       return (pwm < tri_level(k)) ? 3'b111 : 3'b000;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic [2:0] exp_led;
    @(posedge CLK);
    #1;
    cyc++;
    if (RST) begin
      r_edge   = cyc;
      t0       = cyc;
      exp_mode = 0;
      evt_edge = -1;
      exp_led  = 3'b111;
    end else begin
      if (cyc == evt_edge) begin
        exp_mode = (exp_mode + 1) % 4;
        t0       = cyc;
      end
      exp_led = ~lit_prev;
    end
    check("mode", bus.MODE, exp_mode);
    check("step_tick", bus.STEP_TICK, ((cyc - t0) % 4) == 3);
    check("led", bus.LED, exp_led);
    lit_prev = model_lit();
  endtask

  task automatic press(int low, int high);
    bus.KEY  = 1'b0;
    evt_edge = cyc + 11;
    repeat (low) step();
    bus.KEY = 1'b1;
    repeat (high) step();
  endtask

  task automatic count_lit(int n, output int c);
    c = 0;
    repeat (n) begin
      step();
      if (bus.LED === 3'b000) c++;
    end
  endtask

  initial begin
    int m;
    int r;
    int c;

    vecs[0]  = '{1'b1,  1, 3'b111, 1'b0, 2'd0};
    vecs[1]  = '{1'b1,  3, 3'b111, 1'b1, 2'd0};
    vecs[2]  = '{1'b1,  4, 3'b111, 1'b0, 2'd0};
    vecs[3]  = '{1'b1,  5, 3'b110, 1'b0, 2'd0};
    vecs[4]  = '{1'b1,  7, 3'b110, 1'b1, 2'd0};
    vecs[5]  = '{1'b1,  9, 3'b101, 1'b0, 2'd0};
    vecs[6]  = '{1'b1, 13, 3'b100, 1'b0, 2'd0};
    vecs[7]  = '{1'b1, 17, 3'b011, 1'b0, 2'd0};
    vecs[8]  = '{1'b1, 21, 3'b010, 1'b0, 2'd0};
    vecs[9]  = '{1'b1, 25, 3'b001, 1'b0, 2'd0};
    vecs[10] = '{1'b1, 29, 3'b000, 1'b0, 2'd0};
    vecs[11] = '{1'b1, 32, 3'b000, 1'b0, 2'd0};
    vecs[12] = '{1'b1, 33, 3'b111, 1'b0, 2'd0};
    vecs[13] = '{1'b1, 35, 3'b111, 1'b1, 2'd0};
    vecs[14] = '{1'b1, 37, 3'b110, 1'b0, 2'd0};
    vecs[15] = '{1'b1, 40, 3'b110, 1'b0, 2'd0};

    RST     = 1'b1;
    bus.KEY = 1'b1;
    repeat (3) step();
    check("rst_led", bus.LED, 3'b111);
    check("rst_tick", bus.STEP_TICK, 1'b0);
    RST = 1'b0;

    // binary counting from reset
    foreach (vecs[i]) begin
      bus.KEY = vecs[i].key;
      while (cyc - r_edge < vecs[i].at) step();
      check("tbl_led", bus.LED, vecs[i].led);
      check("tbl_tick", bus.STEP_TICK, vecs[i].tick);
      check("tbl_mode", bus.MODE, vecs[i].mode);
    end

    // long press into ONE_HOT, then release
    bus.KEY  = 1'b0;
    evt_edge = cyc + 11;
    repeat (10) step();
    check("press_edge10", bus.MODE, 2'd0);
    step();
    check("press_edge11", bus.MODE, 2'd1);
    step();
    check("onehot_a", bus.LED, 3'b110);
    repeat (4) step();
    check("onehot_b", bus.LED, 3'b101);
    repeat (4) step();
    check("onehot_c", bus.LED, 3'b011);
    bus.KEY = 1'b1;
    repeat (4) step();
    check("onehot_wrap", bus.LED, 3'b110);
    repeat (16) step();
    check("release_no_evt", bus.MODE, 2'd1);

    // short glitches are rejected and do not restart the prescaler
    for (int g = 0; g < 4; g++) begin
      bus.KEY = 1'b0;
      repeat (5) step();
      bus.KEY = 1'b1;
      repeat (3) step();
    end
    repeat (12) step();
    check("glitch_mode", bus.MODE, 2'd1);

    // reset, then two presses into BREATHE
    RST = 1'b1;
    step();
    RST = 1'b0;
    r = cyc;
    press(14, 14);
    bus.KEY  = 1'b0;
    evt_edge = cyc + 11;
    repeat (11) step();
    m = cyc;
    check("breathe_entry_edge", m - r, 39);
    check("breathe_mode", bus.MODE, 2'd2);
    count_lit(4, c);
    check("breathe_level0_lit", c, 0);
    bus.KEY = 1'b1;
    while (cyc < m + 24) step();
    count_lit(4, c);
    check("breathe_level6_lit", c, 3);
    count_lit(4, c);
    check("breathe_level7_lit", c, 4);
    while (cyc < m + 56) step();
    count_lit(4, c);
    check("breathe_bottom_lit", c, 0);

    // reset while at level 5
    while (cyc < m + 77) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    r = cyc;
    check("rst_mid_mode", bus.MODE, 2'd0);
    check("rst_mid_led", bus.LED, 3'b111);
    check("rst_mid_tick", bus.STEP_TICK, 1'b0);
    step();
    check("rst_tick1", bus.STEP_TICK, 1'b0);
    step();
    check("rst_tick2", bus.STEP_TICK, 1'b0);
    step();
    check("rst_tick3", bus.STEP_TICK, 1'b1);

    // key event coincident with the step that would move pattern 5 to 6
    while (cyc < r + 13) step();
    bus.KEY  = 1'b0;
    evt_edge = cyc + 11;
    while (cyc < r + 23) step();
    check("coinc_led5", bus.LED, 3'b010);
    check("coinc_tick", bus.STEP_TICK, 1'b1);
    step();
    check("coinc_mode", bus.MODE, 2'd1);
    check("coinc_tick_gone", bus.STEP_TICK, 1'b0);
    step();
    check("coinc_pattern1", bus.LED, 3'b110);
    step();
    check("coinc_tick_r26", bus.STEP_TICK, 1'b0);
    step();
    check("coinc_tick_r27", bus.STEP_TICK, 1'b1);
    bus.KEY = 1'b1;
    repeat (20) step();
    check("final_mode", bus.MODE, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
